// File: rtl/frequency_gate_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// frequency_gate_sequencer_pkg
// Shared definitions for the frequency counter gate sequencer and the
// accumulator stage it talks to:
//   - FSM state encoding (IDLE, GATE, SETTLE, REQ, REL, HOLDOFF)
//   - default gate length
//   - four-phase handshake level constants
//   - helper that sizes the shared cycle counter
// No ports (package).
// -----------------------------------------------------------------------------
package frequency_gate_sequencer_pkg;

    typedef enum logic [2:0] {
        FGS_IDLE    = 3'd0,
        FGS_GATE    = 3'd1,
        FGS_SETTLE  = 3'd2,
        FGS_REQ     = 3'd3,
        FGS_REL     = 3'd4,
        FGS_HOLDOFF = 3'd5
    } fgs_state_e;

    // 2^27 reference cycles: a 1 s window at 134.217728 MHz.
    localparam int unsigned FGS_DEFAULT_GATE_CYCLES = 134217728;

    // Four-phase handshake levels on latch_req.
    localparam logic FGS_REQ_ASSERT  = 1'b1;
    localparam logic FGS_REQ_RELEASE = 1'b0;

    function automatic int unsigned fgs_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One counter is shared by every timed state, so it must hold the largest
    // terminal count of any of them. SETTLE and HOLDOFF are included so that
    // unusually long settle/holdoff settings can never overflow it either.
    function automatic int unsigned fgs_counter_width(
        input int unsigned gate_cycles,
        input int unsigned settle_cycles,
        input int unsigned timeout_cycles,
        input int unsigned holdoff_cycles
    );
        int unsigned m;
        m = fgs_max(fgs_max(gate_cycles, timeout_cycles),
                    fgs_max(settle_cycles, holdoff_cycles));
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/frequency_gate_sequencer_bit_synchronizer.sv
// -----------------------------------------------------------------------------
// bit_synchronizer
// Multi-flop synchronizer bringing a single asynchronous level into the
// clk_i domain. All flops clear on a synchronous active-high reset.
// Ports:
//   clk_i    in   destination clock
//   reset_i  in   synchronous, active-high reset
//   d_i      in   asynchronous level
//   q_o      out  synchronized level, STAGES clk_i edges of latency
// -----------------------------------------------------------------------------
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/frequency_gate_sequencer.sv
// -----------------------------------------------------------------------------
// frequency_gate_sequencer
// Generates the measurement gate for the frequency counter in the
// reference_clock domain. The gate is held open for exactly GATE_CYCLES
// cycles, then held low for SETTLE_CYCLES, after which a four-phase req/ack
// handshake asks the measured-clock accumulator to latch its result and
// clear. A HOLDOFF period separates consecutive windows.
// Ports:
//   reference_clock  in   clock, all state on posedge
//   reset            in   synchronous, active-high
//   enable           in   run continuous windows while high
//   latch_ack_async  in   ack level from the measured-clock domain
//   gate             out  measurement window (registered)
//   latch_req        out  four-phase request level (registered)
//   window_done      out  one-cycle pulse, new result valid downstream
//   window_count     out  completed windows, wraps
//   timeout          out  sticky: a handshake ran out of time
//   busy             out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module frequency_gate_sequencer
    import frequency_gate_sequencer_pkg::*;
#(
    parameter int unsigned GATE_CYCLES        = FGS_DEFAULT_GATE_CYCLES,
    parameter int unsigned SETTLE_CYCLES      = 16,
    parameter int unsigned ACK_TIMEOUT_CYCLES = 1024,
    parameter int unsigned HOLDOFF_CYCLES     = 4,
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned COUNT_WIDTH        = 16
) (
    input  logic                   reference_clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   latch_ack_async,
    output logic                   gate,
    output logic                   latch_req,
    output logic                   window_done,
    output logic [COUNT_WIDTH-1:0] window_count,
    output logic                   timeout,
    output logic                   busy
);

    localparam int unsigned CNT_W = fgs_counter_width(GATE_CYCLES, SETTLE_CYCLES,
                                                      ACK_TIMEOUT_CYCLES, HOLDOFF_CYCLES);
    typedef logic [CNT_W-1:0] cnt_t;

    // Terminal values of the shared counter in each timed state.
    localparam cnt_t GATE_LAST    = cnt_t'(GATE_CYCLES - 1);
    localparam cnt_t SETTLE_LAST  = cnt_t'(SETTLE_CYCLES - 1);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(ACK_TIMEOUT_CYCLES - 1);
    localparam cnt_t HOLDOFF_LAST = cnt_t'(HOLDOFF_CYCLES - 1);
    localparam cnt_t CNT_ONE      = cnt_t'(1);

    logic ack_sync;

    fgs_state_e             state_q,        state_d;
    cnt_t                   cnt_q,          cnt_d;
    logic                   gate_q,         gate_d;
    logic                   latch_req_q,    latch_req_d;
    logic                   window_done_q,  window_done_d;
    logic [COUNT_WIDTH-1:0] window_count_q, window_count_d;
    logic                   timeout_q,      timeout_d;
    logic                   busy_q,         busy_d;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i   (reference_clock),
        .reset_i (reset),
        .d_i     (latch_ack_async),
        .q_o     (ack_sync)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        gate_d         = gate_q;
        latch_req_d    = latch_req_q;
        window_done_d  = 1'b0;
        window_count_d = window_count_q;
        timeout_d      = timeout_q;

        case (state_q)
            FGS_IDLE: begin
                // Never open a window while the accumulator still shows ack.
                if (enable && !ack_sync) begin
                    state_d = FGS_GATE;
                    cnt_d   = '0;
                    gate_d  = 1'b1;
                end
            end

            FGS_GATE: begin
                // enable is deliberately ignored here: a started window always
                // runs to completion so the result is never truncated.
                if (cnt_q == GATE_LAST) begin
                    state_d = FGS_SETTLE;
                    cnt_d   = '0;
                    gate_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            FGS_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d     = FGS_REQ;
                    cnt_d       = '0;
                    latch_req_d = FGS_REQ_ASSERT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            FGS_REQ, FGS_REL: begin
                // The timeout budget covers both handshake phases together,
                // so the counter is only cleared on REQ entry. Running out of
                // budget takes priority over a same-cycle ack edge.
                if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = FGS_HOLDOFF;
                    cnt_d       = '0;
                    latch_req_d = FGS_REQ_RELEASE;
                    timeout_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (state_q == FGS_REQ) begin
                        if (ack_sync) begin
                            state_d     = FGS_REL;
                            latch_req_d = FGS_REQ_RELEASE;
                        end
                    end else if (!ack_sync) begin
                        state_d        = FGS_HOLDOFF;
                        cnt_d          = '0;
                        window_done_d  = 1'b1;
                        window_count_d = window_count_q + 1'b1;
                    end
                end
            end

            FGS_HOLDOFF: begin
                // The counter saturates at its terminal value; leaving also
                // waits for the accumulator to drop ack.
                if (cnt_q == HOLDOFF_LAST) begin
                    if (!ack_sync) begin
                        cnt_d = '0;
                        if (enable) begin
                            state_d = FGS_GATE;
                            gate_d  = 1'b1;
                        end else begin
                            state_d = FGS_IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d     = FGS_IDLE;
                cnt_d       = '0;
                gate_d      = 1'b0;
                latch_req_d = FGS_REQ_RELEASE;
            end
        endcase

        busy_d = (state_d != FGS_IDLE);
    end

    always_ff @(posedge reference_clock) begin
        if (reset) begin
            state_q        <= FGS_IDLE;
            cnt_q          <= '0;
            gate_q         <= 1'b0;
            latch_req_q    <= 1'b0;
            window_done_q  <= 1'b0;
            window_count_q <= '0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            gate_q         <= gate_d;
            latch_req_q    <= latch_req_d;
            window_done_q  <= window_done_d;
            window_count_q <= window_count_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign gate         = gate_q;
    assign latch_req    = latch_req_q;
    assign window_done  = window_done_q;
    assign window_count = window_count_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_frequency_gate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frequency_gate_sequencer
// Self-checking bench for frequency_gate_sequencer. An accumulator-side
// responder echoes latch_req back as latch_ack_async after a short delay,
// and can be disabled or forced high. Window timing is measured from the
// outputs and compared with values computed from the parameters.
// -----------------------------------------------------------------------------
module tb_frequency_gate_sequencer;

    localparam int G    = 100;
    localparam int S    = 4;
    localparam int T    = 50;
    localparam int H    = 4;
    localparam int SY   = 2;
    localparam int CWID = 4;

    logic            reference_clock = 1'b0;
    logic            reset           = 1'b1;
    logic            enable          = 1'b0;
    logic            latch_ack_async = 1'b0;
    logic            gate;
    logic            latch_req;
    logic            window_done;
    logic [CWID-1:0] window_count;
    logic            timeout;
    logic            busy;

    int errors = 0;
    int checks = 0;

    // Accumulator-side responder.
    bit         ack_en    = 1'b1;
    bit         ack_force = 1'b0;
    int         ack_delay = 3;
    logic [7:0] req_hist  = '0;

    frequency_gate_sequencer #(
        .GATE_CYCLES        (G),
        .SETTLE_CYCLES      (S),
        .ACK_TIMEOUT_CYCLES (T),
        .HOLDOFF_CYCLES     (H),
        .SYNC_STAGES        (SY),
        .COUNT_WIDTH        (CWID)
    ) dut (
        .reference_clock (reference_clock),
        .reset           (reset),
        .enable          (enable),
        .latch_ack_async (latch_ack_async),
        .gate            (gate),
        .latch_req       (latch_req),
        .window_done     (window_done),
        .window_count    (window_count),
        .timeout         (timeout),
        .busy            (busy)
    );

    always #5 reference_clock = ~reference_clock;

    always @(negedge reference_clock) begin
        req_hist = {req_hist[6:0], latch_req};
        latch_ack_async = ack_force | (ack_en & req_hist[3'(ack_delay - 1)]);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge reference_clock);
        #1;
    endtask

    task automatic wait_level(input logic lvl, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= limit; i++) begin
            if (gate === lvl) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // Starting at a sample where gate has just risen, follow one window until
    // the next gate rise or until the FSM returns to idle.
    task automatic measure_window(
        input  int          drop_at,
        input  int          force_len,
        output int          high_len,
        output int          settle_len,
        output int          dones,
        output logic [CWID-1:0] cnt_at_done,
        output int          gap,
        output bit          ended_idle,
        output bit          ok
    );
        int guard;
        bit seen_done;
        high_len = 0; settle_len = 0; dones = 0; cnt_at_done = '0;
        gap = 0; ended_idle = 1'b0; ok = 1'b1; seen_done = 1'b0; guard = 0;
        while (gate === 1'b1 && guard < 400) begin
            high_len++;
            if (high_len == drop_at) enable = 1'b0;
            tick();
            guard++;
        end
        while (gate === 1'b0 && latch_req !== 1'b1 && guard < 400) begin
            settle_len++;
            tick();
            guard++;
        end
        if (guard >= 400) ok = 1'b0;
        guard = 0;
        while (ok) begin
            tick();
            guard++;
            if (seen_done) begin
                gap++;
                if (gap == force_len) ack_force = 1'b0;
            end
            if (window_done === 1'b1) begin
                dones++;
                if (!seen_done) begin
                    seen_done   = 1'b1;
                    cnt_at_done = window_count;
                    if (force_len > 0) ack_force = 1'b1;
                end
            end
            if (gate === 1'b1) break;
            if (busy === 1'b0) begin
                ended_idle = 1'b1;
                break;
            end
            if (guard >= 600) ok = 1'b0;
        end
        ack_force = 1'b0;
    endtask

    task automatic start_run();
        bit ok;
        reset = 1'b1; enable = 1'b0; ack_force = 1'b0; ack_en = 1'b1; ack_delay = 3;
        tick(); tick();
        reset = 1'b0; enable = 1'b1;
        wait_level(1'b1, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL start_gate: gate=%b, expected 1 within 10 cycles of enable", gate);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0;
        tick(); tick(); tick();
        checks++; if (gate !== 1'b0) begin errors++; $display("FAIL reset_gate: got %b expected 0", gate); end
        checks++; if (latch_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", latch_req); end
        checks++; if (window_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", window_done); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (window_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", window_count); end
    endtask

    task automatic check_window(input string tag, input int exp_cnt, input int exp_gap,
                                input bit exp_idle);
        int hl, sl, dn, gp; logic [CWID-1:0] cd; bit idl, ok;
        measure_window(-1, 0, hl, sl, dn, cd, gp, idl, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_progress: window stalled, got ok=%0d expected 1", tag, ok); end
        checks++; if (hl != G) begin errors++; $display("FAIL %s_gate_len: got %0d expected %0d", tag, hl, G); end
        checks++; if (sl != S) begin errors++; $display("FAIL %s_settle: got %0d expected %0d", tag, sl, S); end
        checks++; if (dn != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, dn); end
        checks++; if (cd !== CWID'(exp_cnt)) begin errors++; $display("FAIL %s_count: got %0d expected %0d", tag, cd, exp_cnt); end
        checks++; if (idl != exp_idle) begin errors++; $display("FAIL %s_end_idle: got %0d expected %0d", tag, idl, exp_idle); end
        if (!exp_idle) begin
            checks++; if (gp != exp_gap) begin errors++; $display("FAIL %s_holdoff: got %0d expected %0d", tag, gp, exp_gap); end
        end
    endtask

    task automatic test_three_windows();
        start_run();
        for (int w = 0; w < 3; w++) check_window($sformatf("win%0d", w), w + 1, H, 1'b0);
    endtask

    task automatic test_timeout();
        int n; bit saw_done, ok;
        ack_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (latch_req === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        checks++; if (!ok) begin errors++; $display("FAIL to_req_rise: latch_req=%b expected 1 within 300 cycles", latch_req); end
        n = 0; saw_done = 1'b0;
        while (timeout !== 1'b1 && n < 200) begin
            tick(); n++;
            if (window_done === 1'b1) saw_done = 1'b1;
        end
        checks++; if (n != T) begin errors++; $display("FAIL to_latency: got %0d cycles expected %0d", n, T); end
        checks++; if (latch_req !== 1'b0) begin errors++; $display("FAIL to_req_drop: got %b expected 0", latch_req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy: got %b expected 1", busy); end
        repeat (10) begin
            tick();
            if (window_done === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL to_no_done: got window_done pulse expected none"); end
        checks++; if (window_count !== CWID'(3)) begin errors++; $display("FAIL to_count: got %0d expected 3", window_count); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout); end
    endtask

    task automatic test_reset_mid_window();
        bit ok;
        ack_en = 1'b1;
        wait_level(1'b0, 300, ok);
        if (ok) wait_level(1'b1, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_wait_gate: gate=%b expected a new window within 600 cycles", gate); end
        repeat (30) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
        reset = 1'b1;
        tick();
        checks++; if (gate !== 1'b0) begin errors++; $display("FAIL rst_gate_gate: got %b expected 0", gate); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_gate_busy: got %b expected 0", busy); end
        checks++; if (window_count !== '0) begin errors++; $display("FAIL rst_gate_count: got %0d expected 0", window_count); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_gate_timeout: got %b expected 0", timeout); end
        reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (latch_req === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        checks++; if (!ok) begin errors++; $display("FAIL rst_req_rise: latch_req=%b expected 1 within 300 cycles", latch_req); end
        reset = 1'b1;
        tick();
        checks++; if (latch_req !== 1'b0) begin errors++; $display("FAIL rst_req_req: got %b expected 0", latch_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_req_busy: got %b expected 0", busy); end
        checks++; if (gate !== 1'b0) begin errors++; $display("FAIL rst_req_gate: got %b expected 0", gate); end
        checks++; if (window_count !== '0) begin errors++; $display("FAIL rst_req_count: got %0d expected 0", window_count); end
    endtask

    task automatic test_wrap();
        int exp_cnt;
        start_run();
        exp_cnt = 0;
        for (int w = 0; w < 17; w++) begin
            ack_delay = $urandom_range(1, 6);
            exp_cnt = (exp_cnt + 1) % (1 << CWID);
            check_window($sformatf("wrap%0d", w), exp_cnt, H, 1'b0);
        end
    endtask

    task automatic test_ack_holdoff();
        int hl, sl, dn, gp, fl, exp_gap; logic [CWID-1:0] cd; bit idl, ok;
        start_run();
        for (int w = 0; w < 2; w++) begin
            fl = (w == 0) ? 20 : int'($urandom_range(8, 30));
            // Ack must clear the synchronizer before HOLDOFF may exit.
            exp_gap = (fl + SY + 1 > H) ? fl + SY + 1 : H;
            measure_window(-1, fl, hl, sl, dn, cd, gp, idl, ok);
            checks++; if (!ok) begin errors++; $display("FAIL hold%0d_progress: window stalled", w); end
            checks++; if (cd !== CWID'(w + 1)) begin errors++; $display("FAIL hold%0d_count: got %0d expected %0d", w, cd, w + 1); end
            checks++; if (gp != exp_gap) begin errors++; $display("FAIL hold%0d_gap: got %0d expected %0d (force %0d)", w, gp, exp_gap, fl); end
        end
        check_window("hold_after", 3, H, 1'b0);
    endtask

    task automatic test_enable_drop();
        int hl, sl, dn, gp, drop; logic [CWID-1:0] cd; bit idl, ok, stray;
        start_run();
        for (int w = 0; w < 2; w++) begin
            drop = (w == 0) ? 50 : int'($urandom_range(1, G - 1));
            if (w == 1) begin
                enable = 1'b1;
                wait_level(1'b1, 10, ok);
                checks++; if (!ok) begin errors++; $display("FAIL drop_restart: gate=%b expected 1", gate); end
            end
            measure_window(drop, 0, hl, sl, dn, cd, gp, idl, ok);
            checks++; if (hl != G) begin errors++; $display("FAIL drop%0d_gate_len: got %0d expected %0d (drop at %0d)", w, hl, G, drop); end
            checks++; if (dn != 1) begin errors++; $display("FAIL drop%0d_done: got %0d expected 1", w, dn); end
            checks++; if (cd !== CWID'(w + 1)) begin errors++; $display("FAIL drop%0d_count: got %0d expected %0d", w, cd, w + 1); end
            checks++; if (!idl) begin errors++; $display("FAIL drop%0d_idle: got busy=%b expected 0", w, busy); end
            stray = 1'b0;
            repeat (20) begin
                tick();
                if (gate !== 1'b0 || busy !== 1'b0) stray = 1'b1;
            end
            checks++; if (stray) begin errors++; $display("FAIL drop%0d_stays_idle: got activity expected gate=0 busy=0", w); end
        end
    endtask

    initial begin
        test_reset();
        test_three_windows();
        test_timeout();
        test_reset_mid_window();
        test_wrap();
        test_ack_holdoff();
        test_enable_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
